// File: rtl/race_pkg.sv
// Shared types and constants for the race resolver.
// The optional conflict counter is enabled by defining RACE_RESOLVER_CNT_EN.
package race_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK0 = 2'd1,
    ACK1 = 2'd2
  } state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

endpackage

// File: rtl/race_resolver_if.sv
// Bus between two writers and the race resolver.
// conflict_cnt exists only when RACE_RESOLVER_CNT_EN is defined.
interface race_resolver_if
  import race_pkg::*;
#(
  parameter int W = 8
);

  logic         req0;
  logic [W-1:0] val0;
  logic         req1;
  logic [W-1:0] val1;
  logic         ack0;
  logic         ack1;
  logic [W-1:0] x;
  logic         conflict;
`ifdef RACE_RESOLVER_CNT_EN
  logic [CNT_W-1:0] conflict_cnt;
`endif

  modport master (
    output req0, val0, req1, val1,
    input  ack0, ack1, x, conflict
`ifdef RACE_RESOLVER_CNT_EN
    , input conflict_cnt
`endif
  );

  modport slave (
    input  req0, val0, req1, val1,
    output ack0, ack1, x, conflict
`ifdef RACE_RESOLVER_CNT_EN
    , output conflict_cnt
`endif
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester arbiter with one-hot grant.
// FAIR != 0: a pointer favours the port not granted last; FAIR == 0: port 0 wins.
module rr_arb2 #(
  parameter int FAIR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // ptr = 1 means port 1 is favoured on the next simultaneous request
  logic ptr;

  // Combinational grant, only while the owner is sampling requests
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ((FAIR != 0) && ptr) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Pointer moves on every grant so the other port is favoured next time
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if ((FAIR != 0) && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/race_resolver.sv
// Resolves two racing writers onto a single register x.
// One commit per two cycles; requests are sampled only in IDLE.
// Define RACE_RESOLVER_CNT_EN to add a saturating conflict counter.
module race_resolver
  import race_pkg::*;
#(
  parameter int W    = 8,
  parameter int FAIR = 1
) (
  input  logic           clk,
  input  logic           rst,
  race_resolver_if.slave bus
);

  state_t       state, state_next;
  logic [W-1:0] x_q, x_next;
  logic         ack0_q, ack0_next;
  logic         ack1_q, ack1_next;
  logic         conflict_q, conflict_next;
  logic         arb_en;
  logic [1:0]   grant;

  rr_arb2 #(.FAIR(FAIR)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req   ({bus.req1, bus.req0}),
    .grant (grant)
  );

  // Next-state and next-output logic; only IDLE listens to requests
  always_comb begin
    state_next    = state;
    x_next        = x_q;
    ack0_next     = 1'b0;
    ack1_next     = 1'b0;
    conflict_next = 1'b0;
    arb_en        = 1'b0;
    case (state)
      IDLE: begin
        arb_en = 1'b1;
        if (grant[0]) begin
          state_next    = ACK0;
          x_next        = bus.val0;
          ack0_next     = 1'b1;
          conflict_next = bus.req1;
        end else if (grant[1]) begin
          state_next    = ACK1;
          x_next        = bus.val1;
          ack1_next     = 1'b1;
          conflict_next = bus.req0;
        end
      end
      ACK0, ACK1: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // State and registered outputs; reset overrides any request
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x_q        <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state      <= state_next;
      x_q        <= x_next;
      ack0_q     <= ack0_next;
      ack1_q     <= ack1_next;
      conflict_q <= conflict_next;
    end
  end

  assign bus.x        = x_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.conflict = conflict_q;

`ifdef RACE_RESOLVER_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count conflicts alongside the conflict pulse, saturating at CNT_MAX
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (conflict_next && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_race_resolver.sv
// Directed bench for race_resolver: one fair instance, one fixed-priority.
// Counter scenarios are built in when RACE_RESOLVER_CNT_EN is defined.
module tb_race_resolver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  race_resolver_if #(.W(8)) bf ();
  race_resolver_if #(.W(8)) bx ();

  race_resolver #(.W(8), .FAIR(1)) dut_fair (
    .clk (clk),
    .rst (rst),
    .bus (bf.slave)
  );

  race_resolver #(.W(8), .FAIR(0)) dut_fixed (
    .clk (clk),
    .rst (rst),
    .bus (bx.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bf.req0 = 1'b0; bf.req1 = 1'b0; bf.val0 = '0; bf.val1 = '0;
    bx.req0 = 1'b0; bx.req1 = 1'b0; bx.val0 = '0; bx.val1 = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    bf.req0 = 1'b1; bf.val0 = 8'hFF;
    bf.req1 = 1'b1; bf.val1 = 8'hEE;
    rst = 1'b1;
    tick();
    tick();
    if (bf.x !== 8'h00) begin errors++; $display("[TB] FAIL reset_x got %h want 00", bf.x); end
    checks++;
    if ({bf.ack0, bf.ack1, bf.conflict} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags got %b want 000", {bf.ack0, bf.ack1, bf.conflict});
    end
    checks++;
    if (bx.x !== 8'h00) begin errors++; $display("[TB] FAIL reset_x_fixed got %h want 00", bx.x); end
    checks++;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    bf.req0 = 1'b1; bf.val0 = 8'hA5;
    tick();
    if (bf.x !== 8'hA5 || bf.ack0 !== 1'b1 || bf.conflict !== 1'b0) begin
      errors++; $display("[TB] FAIL single0_commit got x=%h ack0=%b cf=%b want A5 1 0", bf.x, bf.ack0, bf.conflict);
    end
    checks++;
    bf.req0 = 1'b0;
    tick();
    if (bf.ack0 !== 1'b0 || bf.x !== 8'hA5) begin
      errors++; $display("[TB] FAIL single0_release got ack0=%b x=%h want 0 A5", bf.ack0, bf.x);
    end
    checks++;
    bf.req1 = 1'b1; bf.val1 = 8'h3C;
    tick();
    if (bf.x !== 8'h3C || bf.ack1 !== 1'b1 || bf.ack0 !== 1'b0) begin
      errors++; $display("[TB] FAIL single1_commit got x=%h ack1=%b ack0=%b want 3C 1 0", bf.x, bf.ack1, bf.ack0);
    end
    checks++;
    bf.req1 = 1'b0;
    tick();
    if (bf.ack1 !== 1'b0) begin errors++; $display("[TB] FAIL single1_release got ack1=%b want 0", bf.ack1); end
    checks++;
  endtask

  task automatic test_conflict_fair();
    do_reset();
    bf.req0 = 1'b1; bf.val0 = 8'h11;
    bf.req1 = 1'b1; bf.val1 = 8'h22;
    tick();
    if (bf.x !== 8'h11 || bf.ack0 !== 1'b1 || bf.ack1 !== 1'b0 || bf.conflict !== 1'b1) begin
      errors++; $display("[TB] FAIL fair_first got x=%h a0=%b a1=%b cf=%b want 11 1 0 1", bf.x, bf.ack0, bf.ack1, bf.conflict);
    end
    checks++;
    bf.req0 = 1'b0;
    tick();
    if (bf.x !== 8'h11 || bf.ack0 !== 1'b0 || bf.ack1 !== 1'b0 || bf.conflict !== 1'b0) begin
      errors++; $display("[TB] FAIL fair_gap got x=%h a0=%b a1=%b cf=%b want 11 0 0 0", bf.x, bf.ack0, bf.ack1, bf.conflict);
    end
    checks++;
    tick();
    if (bf.x !== 8'h22 || bf.ack1 !== 1'b1 || bf.conflict !== 1'b0) begin
      errors++; $display("[TB] FAIL fair_loser got x=%h a1=%b cf=%b want 22 1 0", bf.x, bf.ack1, bf.conflict);
    end
    checks++;
    bf.req1 = 1'b0;
    tick();
    if (bf.x !== 8'h22 || bf.ack1 !== 1'b0) begin
      errors++; $display("[TB] FAIL fair_final got x=%h a1=%b want 22 0", bf.x, bf.ack1);
    end
    checks++;
  endtask

  task automatic test_fair_alternation();
    logic [7:0] expv [4];
    expv[0] = 8'h55; expv[1] = 8'hAA; expv[2] = 8'h55; expv[3] = 8'hAA;
    do_reset();
    bf.req0 = 1'b1; bf.val0 = 8'h55;
    bf.req1 = 1'b1; bf.val1 = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bf.x !== expv[i] || bf.conflict !== 1'b1 || (bf.ack0 ^ bf.ack1) !== 1'b1) begin
        errors++; $display("[TB] FAIL fair_alt%0d got x=%h cf=%b a0=%b a1=%b want %h 1 one-ack", i, bf.x, bf.conflict, bf.ack0, bf.ack1, expv[i]);
      end
      checks++;
      tick();
    end
    idle_all();
  endtask

  task automatic test_fixed_priority();
    int n0 = 0;
    int n1 = 0;
    do_reset();
    bx.req0 = 1'b1; bx.val0 = 8'h77;
    bx.req1 = 1'b1; bx.val1 = 8'h88;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bx.ack0 === 1'b1) n0++;
      if (bx.ack1 === 1'b1) n1++;
    end
    if (n0 !== 5) begin errors++; $display("[TB] FAIL fixed_ack0_count got %0d want 5", n0); end
    checks++;
    if (n1 !== 0) begin errors++; $display("[TB] FAIL fixed_ack1_count got %0d want 0", n1); end
    checks++;
    if (bx.x !== 8'h77) begin errors++; $display("[TB] FAIL fixed_x got %h want 77", bx.x); end
    checks++;
    idle_all();
  endtask

  task automatic test_reset_in_ack();
    do_reset();
    bf.req1 = 1'b1; bf.val1 = 8'hC3;
    tick();
    if (bf.ack1 !== 1'b1 || bf.x !== 8'hC3) begin
      errors++; $display("[TB] FAIL rstack_pre got a1=%b x=%h want 1 C3", bf.ack1, bf.x);
    end
    checks++;
    rst = 1'b1;
    tick();
    if (bf.ack1 !== 1'b0 || bf.x !== 8'h00) begin
      errors++; $display("[TB] FAIL rstack_cancel got a1=%b x=%h want 0 00", bf.ack1, bf.x);
    end
    checks++;
    rst = 1'b0;
    tick();
    if (bf.ack1 !== 1'b1 || bf.x !== 8'hC3) begin
      errors++; $display("[TB] FAIL rstack_rereq got a1=%b x=%h want 1 C3", bf.ack1, bf.x);
    end
    checks++;
    bf.req1 = 1'b0;
    tick();
  endtask

  task automatic test_dropped_request();
    do_reset();
    bf.req1 = 1'b1; bf.val1 = 8'h5A;
    tick();
    bf.req1 = 1'b0;
    bf.req0 = 1'b1; bf.val0 = 8'hE7;
    tick();
    if (bf.ack0 !== 1'b0 || bf.ack1 !== 1'b0 || bf.x !== 8'h5A || bf.conflict !== 1'b0) begin
      errors++; $display("[TB] FAIL drop_inack got a0=%b a1=%b x=%h cf=%b want 0 0 5A 0", bf.ack0, bf.ack1, bf.x, bf.conflict);
    end
    checks++;
    bf.req0 = 1'b0;
    tick();
    if (bf.ack0 !== 1'b0 || bf.x !== 8'h5A) begin
      errors++; $display("[TB] FAIL drop_after got a0=%b x=%h want 0 5A", bf.ack0, bf.x);
    end
    checks++;
  endtask

`ifdef RACE_RESOLVER_CNT_EN
  task automatic test_conflict_cnt();
    do_reset();
    if (bf.conflict_cnt !== 8'd0) begin errors++; $display("[TB] FAIL cnt_reset got %0d want 0", bf.conflict_cnt); end
    checks++;
    bf.req0 = 1'b1; bf.req1 = 1'b1;
    for (int i = 0; i < 200; i++) tick();
    if (bf.conflict_cnt !== 8'd100) begin errors++; $display("[TB] FAIL cnt_100 got %0d want 100", bf.conflict_cnt); end
    checks++;
    for (int i = 0; i < 400; i++) tick();
    if (bf.conflict_cnt !== 8'd255) begin errors++; $display("[TB] FAIL cnt_sat got %0d want 255", bf.conflict_cnt); end
    checks++;
    for (int i = 0; i < 20; i++) tick();
    if (bf.conflict_cnt !== 8'd255) begin errors++; $display("[TB] FAIL cnt_hold got %0d want 255", bf.conflict_cnt); end
    checks++;
    do_reset();
    tick();
    if (bf.conflict_cnt !== 8'd0) begin errors++; $display("[TB] FAIL cnt_clear got %0d want 0", bf.conflict_cnt); end
    checks++;
  endtask
`endif

  initial begin
    idle_all();
    test_reset();
    test_single();
    test_conflict_fair();
    test_fair_alternation();
    test_fixed_priority();
    test_reset_in_ack();
    test_dropped_request();
`ifdef RACE_RESOLVER_CNT_EN
    test_conflict_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/race_resolver.md
RACE_RESOLVER -- requirements
Module: race_resolver

Interface
REQ-001 Parameter W, default 8: data width of written value and x.
REQ-002 Parameter FAIR, default 1: 1 = round-robin arbitration, 0 = fixed priority, port 0 wins.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 req0  input  1  port-0 write request; held high until ack0 is seen.
REQ-006 val0  input  W  port-0 write value; stable while req0 is high.
REQ-007 req1  input  1  port-1 write request; held high until ack1 is seen.
REQ-008 val1  input  W  port-1 write value; stable while req1 is high.
REQ-009 ack0  output  1  one-cycle pulse: port-0 value committed to x.
REQ-010 ack1  output  1  one-cycle pulse: port-1 value committed to x.
REQ-011 x  output  W  resolved register; the single, deterministic driver for the downstream register.
REQ-012 conflict  output  1  one-cycle pulse: both requests were sampled in the same IDLE cycle.
REQ-013 conflict_cnt  output  8  saturating conflict count; present only when RACE_RESOLVER_CNT_EN is defined.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACK0, ACK1; all outputs SHALL be registered.
REQ-015 Requests SHALL be sampled only in IDLE; in ACK0/ACK1, requests SHALL be ignored and the FSM SHALL return to IDLE on the next edge.
REQ-016 In IDLE, with only reqN high at edge E: after E, x = valN, ackN = 1, state = ACKN; after E+1, ackN = 0, state = IDLE.
REQ-017 Sustained throughput SHALL be one commit per 2 cycles; the earliest next sample is edge E+2.
REQ-018 In IDLE, with req0 and req1 both high: the winner per REQ-019 SHALL commit per REQ-016, conflict SHALL pulse for the same cycle as the ack, and the loser SHALL stay pending and be granted at E+2 if still requesting.
REQ-019 FAIR=1: a 1-bit pointer SHALL favour the port not granted last; it SHALL update on every grant, conflicting or not. FAIR=0: port 0 SHALL always win.
REQ-020 A request dropped before its ack SHALL cause no write, no ack and no conflict.
REQ-021 ack0 and ack1 SHALL never be high in the same cycle; x SHALL change only in a cycle where an ack is asserted.
REQ-022 Values SHALL be committed at full width W without truncation or extension.

Reset
REQ-023 On rst high at an edge: state = IDLE, x = 0, ack0 = ack1 = 0, conflict = 0, pointer favours port 0, conflict_cnt = 0.
REQ-024 rst SHALL override all requests, including those in the same cycle; a reset in ACK0/ACK1 SHALL cancel the pending ack pulse, and the requester SHALL re-request.
REQ-025 The first sample after reset SHALL occur at the first edge with rst low.

Configuration
REQ-026 With RACE_RESOLVER_CNT_EN defined, conflict_cnt SHALL increment on every conflict pulse, saturate at 255, and clear only on rst.
REQ-027 Without RACE_RESOLVER_CNT_EN, the conflict_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package race_pkg SHALL hold the state typedef (IDLE/ACK0/ACK1), CNT_W = 8 and CNT_MAX = 255.
REQ-029 Arbitration SHALL live in sub-module rr_arb2, a 2-requester arbiter with FAIR parameter, pointer and one-hot grant; race_resolver SHALL own the FSM, the x register and the counter.

Verification
REQ-030 Reset, then req0 = 1, val0 = 8'hA5 at edge 1: x = 8'hA5 and ack0 = 1 after edge 1; ack0 = 0 after edge 2.
REQ-031 FAIR=1, req0 = req1 = 1 (val0 = 8'h11, val1 = 8'h22) from reset: x = 8'h11 with conflict = 1, then x = 8'h22 two edges later; final x = 8'h22.
REQ-032 FAIR=0, both requests held continuously with re-request after each ack: port 0 wins every sample and port 1 is never acked.
REQ-033 Assert rst during ACK1: ack1 = 0 and x = 0 after the reset edge; req1 re-issued after reset commits normally.
REQ-034 RACE_RESOLVER_CNT_EN defined, 300 simultaneous-request conflicts: conflict_cnt reads 255 and holds.
REQ-035 req0 pulsed for one cycle while the FSM is in ACK1: no ack0 and x unchanged.
